// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and held-key decoder for game controls (A/D/W/Space).
// Define PS2_ARROWS_EN to also map extended arrow keys onto the same key bits.
module ps2_key_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 65000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // synchronizers
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   clk_s, data_s, fall;

   // receiver
   rx_state_t state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_err_q, rx_err_d;

   // decoder
   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic [3:0] letter_q, letter_d;
   logic [3:0] key_q, key_d;
`ifdef PS2_ARROWS_EN
   logic [2:0] arrow_q, arrow_d;
`endif

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_s       = clk_sync_q[SYNC_STAGES-1];
      data_s      = data_sync_q[SYNC_STAGES-1];
      clk_prev_d  = clk_s;
      fall        = clk_prev_q & ~clk_s;
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tmo_d      = tmo_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;

      if (state_q == IDLE) begin
         tmo_d = '0;
         if (fall && !data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
         end
      end else if (fall) begin
         tmo_d = '0;
         case (state_q)
            DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_d   = data_s;
               state_d = STOP;
            end
            STOP: begin
               // odd parity over data + parity bit, stop bit must be 1
               if (data_s && (^{shift_q, par_q})) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
               state_d   = IDLE;
               bit_cnt_d = '0;
            end
            default: state_d = IDLE;
         endcase
      end else if (tmo_q == TMO_LAST) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         tmo_d     = '0;
         rx_err_d  = 1'b1;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_comb begin
      brk_d    = brk_q;
      ext_d    = ext_q;
      letter_d = letter_q;
`ifdef PS2_ARROWS_EN
      arrow_d  = arrow_q;
`endif
      if (rx_valid_q) begin
         if (rx_byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (rx_byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            if (!ext_q) begin
               case (rx_byte_q)
                  8'h1C:   letter_d[0] = ~brk_q;
                  8'h23:   letter_d[1] = ~brk_q;
                  8'h1D:   letter_d[2] = ~brk_q;
                  8'h29:   letter_d[3] = ~brk_q;
                  default: letter_d    = letter_q;
               endcase
            end
`ifdef PS2_ARROWS_EN
            else begin
               case (rx_byte_q)
                  8'h6B:   arrow_d[0] = ~brk_q;
                  8'h74:   arrow_d[1] = ~brk_q;
                  8'h75:   arrow_d[2] = ~brk_q;
                  default: arrow_d    = arrow_q;
               endcase
            end
`endif
            brk_d = 1'b0;
            ext_d = 1'b0;
         end
      end
`ifdef PS2_ARROWS_EN
      // arrows and letters are tracked apart so releasing one keeps the other
      key_d = letter_d | {1'b0, arrow_d};
`else
      key_d = letter_d;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_err_q    <= 1'b0;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         letter_q    <= '0;
         key_q       <= '0;
`ifdef PS2_ARROWS_EN
         arrow_q     <= '0;
`endif
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_err_q    <= rx_err_d;
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         letter_q    <= letter_d;
         key_q       <= key_d;
`ifdef PS2_ARROWS_EN
         arrow_q     <= arrow_d;
`endif
      end
   end

   assign key      = key_q;
   assign rx_byte  = rx_byte_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frame table plus latency, timeout and reset sequences.
module tb_ps2_key_decoder;

   localparam int unsigned TMO = 200;
`ifdef PS2_ARROWS_EN
   localparam logic [3:0] ARW_K = 4'b0001;
`else
   localparam logic [3:0] ARW_K = 4'b0000;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] key;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   int checks = 0;
   int fails = 0;
   int valid_cnt = 0;
   int err_cnt = 0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key(key), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) valid_cnt++;
      if (rx_err) err_cnt++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      ps2_data = v;
      wait_cyc(4);
      ps2_clk = 1'b0;
      wait_cyc(8);
      ps2_clk = 1'b1;
      wait_cyc(4);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~^b;
      if (bad_par) par = ~par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      send_bit(bad_stop ? 1'b0 : 1'b1);
      ps2_data = 1'b1;
      wait_cyc(4);
   endtask

   typedef struct {
      logic [7:0] b;
      bit         bad_par;
      bit         bad_stop;
      int         v;
      int         e;
      logic [3:0] k;
      logic [7:0] rx;
   } vec_t;

   vec_t vecs[30];

   initial begin
      int v0, e0;
      bit found;

      vecs[0]  = '{8'h1C, 0, 0, 1, 0, 4'b0001, 8'h1C};
      vecs[1]  = '{8'h29, 0, 0, 1, 0, 4'b1001, 8'h29};
      vecs[2]  = '{8'h29, 0, 0, 1, 0, 4'b1001, 8'h29};
      vecs[3]  = '{8'hF0, 0, 0, 1, 0, 4'b1001, 8'hF0};
      vecs[4]  = '{8'h29, 0, 0, 1, 0, 4'b0001, 8'h29};
      vecs[5]  = '{8'h23, 1, 0, 0, 1, 4'b0001, 8'h29};
      vecs[6]  = '{8'h23, 0, 0, 1, 0, 4'b0011, 8'h23};
      vecs[7]  = '{8'h1D, 0, 0, 1, 0, 4'b0111, 8'h1D};
      vecs[8]  = '{8'hF0, 0, 0, 1, 0, 4'b0111, 8'hF0};
      vecs[9]  = '{8'h1C, 0, 0, 1, 0, 4'b0110, 8'h1C};
      vecs[10] = '{8'h55, 0, 0, 1, 0, 4'b0110, 8'h55};
      vecs[11] = '{8'hF0, 0, 0, 1, 0, 4'b0110, 8'hF0};
      vecs[12] = '{8'h23, 0, 0, 1, 0, 4'b0100, 8'h23};
      vecs[13] = '{8'hF0, 0, 0, 1, 0, 4'b0100, 8'hF0};
      vecs[14] = '{8'h1D, 0, 0, 1, 0, 4'b0000, 8'h1D};
      vecs[15] = '{8'hE0, 0, 0, 1, 0, 4'b0000, 8'hE0};
      vecs[16] = '{8'h6B, 0, 0, 1, 0, ARW_K,   8'h6B};
      vecs[17] = '{8'h1C, 0, 0, 1, 0, 4'b0001, 8'h1C};
      vecs[18] = '{8'hE0, 0, 0, 1, 0, 4'b0001, 8'hE0};
      vecs[19] = '{8'hF0, 0, 0, 1, 0, 4'b0001, 8'hF0};
      vecs[20] = '{8'h6B, 0, 0, 1, 0, 4'b0001, 8'h6B};
      vecs[21] = '{8'hF0, 0, 0, 1, 0, 4'b0001, 8'hF0};
      vecs[22] = '{8'h1C, 0, 0, 1, 0, 4'b0000, 8'h1C};
      vecs[23] = '{8'h1C, 0, 1, 0, 1, 4'b0000, 8'h1C};
      vecs[24] = '{8'hE0, 1, 0, 0, 1, 4'b0000, 8'h1C};
      vecs[25] = '{8'h1D, 0, 0, 1, 0, 4'b0100, 8'h1D};
      vecs[26] = '{8'hF0, 1, 0, 0, 1, 4'b0100, 8'h1D};
      vecs[27] = '{8'h1D, 0, 0, 1, 0, 4'b0100, 8'h1D};
      vecs[28] = '{8'hF0, 0, 0, 1, 0, 4'b0100, 8'hF0};
      vecs[29] = '{8'h1D, 0, 0, 1, 0, 4'b0000, 8'h1D};

      // reset values
      wait_cyc(3);
      check("reset_key", 32'(key), 32'h0);
      check("reset_rx_byte", 32'(rx_byte), 32'h0);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_rx_err", 32'(rx_err), 32'h0);
      rst = 1'b0;
      wait_cyc(5);

      // 0x1C frame with cycle-level latency on the stop edge
      v0 = valid_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0);
      send_bit(1'b0);
      ps2_data = 1'b1;
      wait_cyc(4);
      ps2_clk = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         wait_cyc(1);
         if (rx_valid) found = 1'b1;
      end
      check("lat_valid_seen", 32'(found), 32'h1);
      check("lat_rx_byte", 32'(rx_byte), 32'h1C);
      check("lat_key_before", 32'(key), 32'h0);
      wait_cyc(1);
      check("lat_key_after", 32'(key), 32'h1);
      check("lat_valid_pulse", 32'(rx_valid), 32'h0);
      wait_cyc(4);
      ps2_clk = 1'b1;
      wait_cyc(8);
      check("lat_valid_count", 32'(valid_cnt - v0), 32'h1);

      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(4);
      check("rst2_key", 32'(key), 32'h0);

      // frame table
      for (int i = 0; i < 30; i++) begin
         v0 = valid_cnt;
         e0 = err_cnt;
         send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
         check($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].v));
         check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].e));
         check($sformatf("vec%0d_key", i), 32'(key), 32'(vecs[i].k));
         check($sformatf("vec%0d_rx_byte", i), 32'(rx_byte), 32'(vecs[i].rx));
      end

      // timeout: start bit + 3 data bits, then ps2_clk idles high
      v0 = valid_cnt;
      e0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      wait_cyc(150);
      check("tmo_not_early", 32'(err_cnt - e0), 32'h0);
      wait_cyc(80);
      check("tmo_err", 32'(err_cnt - e0), 32'h1);
      check("tmo_no_valid", 32'(valid_cnt - v0), 32'h0);
      check("tmo_rx_byte", 32'(rx_byte), 32'h1D);
      send_frame(8'h1D, 0, 0);
      check("tmo_next_valid", 32'(valid_cnt - v0), 32'h1);
      check("tmo_next_err", 32'(err_cnt - e0), 32'h1);
      check("tmo_next_key", 32'(key), 32'h4);

      // reset after 5th bit of a 0x1C frame
      v0 = valid_cnt;
      e0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(((8'h1C >> i) & 8'h01) != 0);
      rst = 1'b1;
      wait_cyc(3);
      check("mid_rst_key", 32'(key), 32'h0);
      rst = 1'b0;
      wait_cyc(300);
      check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'h0);
      check("mid_rst_no_err", 32'(err_cnt - e0), 32'h0);
      check("mid_rst_key_after", 32'(key), 32'h0);
      check("mid_rst_rx_byte", 32'(rx_byte), 32'h0);
      send_frame(8'h1C, 0, 0);
      check("mid_rst_next_valid", 32'(valid_cnt - v0), 32'h1);
      check("mid_rst_next_err", 32'(err_cnt - e0), 32'h0);
      check("mid_rst_next_key", 32'(key), 32'h1);
      check("mid_rst_next_rx", 32'(rx_byte), 32'h1C);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65000, is the number of idle clk cycles inside a frame after which the frame is abandoned (about 1 ms at 65 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, is the flip-flop depth of the ps2_clk and ps2_data synchronizers (minimum 2).
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 device data, asynchronous to clk.
REQ-007 key  output  4  held-key vector for the game: [0] left, [1] right, [2] up/jump, [3] action; a bit is 1 while its key is held.
REQ-008 rx_byte  output  8  last correctly received scan byte.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_byte is new.
REQ-010 rx_err  output  1  one-cycle pulse; a frame failed start, parity or stop checks, or timed out.

Function
REQ-011 ps2_clk and ps2_data shall each pass through SYNC_STAGES flip-flops; a falling edge is a synchronized 1 followed by a synchronized 0.
REQ-012 The receiver FSM shall have states IDLE, DATA, PARITY and STOP, and it samples synchronized ps2_data on each detected falling edge.
REQ-013 IDLE: a sampled 0 (start bit) goes to DATA with bit count 0; a sampled 1 stays in IDLE with no output.
REQ-014 DATA: the FSM shall shift in 8 bits LSB first and go to PARITY after the 8th bit.
REQ-015 PARITY: the FSM shall sample the parity bit and go to STOP. Parity is valid when the 8 data bits plus the parity bit contain an odd number of 1s.
REQ-016 STOP: a sampled 1 with valid parity shall load rx_byte and pulse rx_valid in the clk cycle after the edge is detected.
REQ-017 STOP: a sampled 0 or a parity mismatch shall pulse rx_err in the same cycle position, leave rx_byte unchanged, and return to IDLE.
REQ-018 Outside IDLE, a cycle counter shall clear on every detected falling edge. When it reaches TIMEOUT_CYCLES-1, the FSM shall discard the partial frame, pulse rx_err and return to IDLE. The counter shall stay at 0 in IDLE.
REQ-019 The decoder shall hold two flags, brk and ext, and process each rx_valid byte exactly once.
REQ-020 Byte 0xF0 shall set brk. Byte 0xE0 shall set ext. Neither byte changes key.
REQ-021 Any other byte with ext=0 shall be looked up: 0x1C sets bit 0 (A), 0x23 bit 1 (D), 0x1D bit 2 (W), 0x29 bit 3 (Space).
REQ-022 For a mapped byte, the addressed held bit becomes ~brk. An unmapped byte leaves key unchanged. After any non-prefix byte, brk and ext shall both clear.
REQ-023 key shall be registered and shall update in the cycle after rx_valid, so total latency is 2 clk cycles after the stop-bit falling edge is detected.
REQ-024 Repeated make codes (typematic) shall leave an already set bit at 1, with no toggling.
REQ-025 Bytes with rx_err shall not affect brk, ext or key.

Reset
REQ-026 While rst is high, the block shall be held in reset: receiver FSM in IDLE, bit count 0, timeout counter 0, synchronizer flops at 1, brk=0, ext=0.
REQ-027 While rst is high, outputs shall read key=4'h0, rx_byte=8'h00, rx_valid=0, rx_err=0.
REQ-028 Reset asserted mid-frame shall discard the frame. After release, reception restarts on the next start bit with no spurious rx_valid or rx_err.

Configuration
REQ-029 With macro PS2_ARROWS_EN defined, bytes with ext=1 shall map as follows: 0x6B to bit 0, 0x74 to bit 1, 0x75 to bit 2. This arrow-key state is held separately from the letter-key state, and key is the OR of the two. Releasing one source does not clear a bit still held by the other.
REQ-030 Without PS2_ARROWS_EN, every byte with ext=1 shall be ignored for key, with flags cleared as in REQ-022, and no arrow-key state shall be synthesized.

Verification
REQ-031 Frame 0x1C (start 0, data 00111000 LSB first, parity 0, stop 1) -> rx_valid pulse, rx_byte=0x1C, key=4'b0001 two cycles after the stop edge.
REQ-032 Sequence 0x29, then 0xF0, 0x29 -> key[3] goes 1 and then returns to 0; rx_valid pulses three times; key[2:0] stay 0.
REQ-033 Frame 0x23 with parity bit 1 -> rx_err pulse, no rx_valid, key unchanged, rx_byte unchanged.
REQ-034 Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> rx_err pulse and FSM in IDLE; the next valid 0x1D frame -> key[2]=1.
REQ-035 With PS2_ARROWS_EN: 0xE0 0x6B, then 0x1C, then 0xE0 0xF0 0x6B -> key[0] stays 1; then 0xF0 0x1C -> key[0]=0. Without the macro: 0xE0 0x6B -> key=0.
REQ-036 rst asserted after the 5th bit of a 0x1C frame, then released -> no pulses and key=0; a following full 0x1C frame decodes normally.
